// File: rtl/ripple_seq_ctrl.sv
// ripple_seq_ctrl: sequencer for an external asynchronous ripple counter.
// Keeps the counter in reset while idle, then issues one count pulse at a
// time on cnt_clk. After each pulse it waits SETTLE cycles and compares
// cnt_q with an internal shadow count. A run ends on reaching the latched
// limit, on a mismatch (sticky err), or on stop.
//
// Optional feature: define RIPPLE_SEQ_AUTO_RELOAD_EN to restart the count
// automatically after every match (done pulses once per run) until stop,
// rst or a mismatch ends the loop.
//
// Handshake: start is a level sampled only in IDLE. It is accepted on any
// clock edge where start=1 and stop=0, and it latches limit on that edge.
// While busy=1, start and limit are ignored. stop aborts any busy state on
// the next edge. done is a one-cycle pulse and err is sticky.
//
// Every output is a register, so the counter clock and reset never glitch.

module ripple_seq_ctrl #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_clk,
   output logic             cnt_rst,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] count_out
);

   // Settle counter runs from 0 to SETTLE-1, so it must hold SETTLE-1.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

`ifdef RIPPLE_SEQ_AUTO_RELOAD_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_PULSE  = 3'd2,
      S_SETTLE = 3'd3,
      S_CHECK  = 3'd4,
      S_RELOAD = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_PULSE  = 3'd2,
      S_SETTLE = 3'd3,
      S_CHECK  = 3'd4
   } state_t;
`endif

   state_t            state;
   logic [WIDTH-1:0]  shadow;
   logic [WIDTH-1:0]  limit_q;
   logic [SW-1:0]     settle_cnt;

   // Sequencer FSM. Each output is registered from the transition it
   // accompanies, so the output value lines up with the state it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt_clk    <= 1'b0;
         cnt_rst    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         count_out  <= '0;
         shadow     <= '0;
         limit_q    <= '0;
         settle_cnt <= '0;
      end else begin
         // The count pulse and done are single-cycle unless re-asserted below.
         cnt_clk <= 1'b0;
         done    <= 1'b0;
         if (stop && (state != S_IDLE)) begin
            // Abort: drop straight back to IDLE, counter back into reset.
            // count_out keeps the last checked value.
            state   <= S_IDLE;
            cnt_rst <= 1'b1;
            busy    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  cnt_rst <= 1'b1;
                  busy    <= 1'b0;
                  if (start && !stop) begin
                     state   <= S_ARM;
                     limit_q <= limit;
                     shadow  <= '0;
                     err     <= 1'b0;
                     cnt_rst <= 1'b0;
                     busy    <= 1'b1;
                  end
               end
               S_ARM: begin
                  // Counter has just left reset; give it a settle window
                  // before the first (zero) check.
                  state      <= S_SETTLE;
                  settle_cnt <= '0;
               end
               S_PULSE: begin
                  shadow     <= shadow + 1'b1;
                  state      <= S_SETTLE;
                  settle_cnt <= '0;
               end
               S_SETTLE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= S_CHECK;
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end
               S_CHECK: begin
                  count_out <= cnt_q;
                  if (cnt_q != shadow) begin
                     err     <= 1'b1;
                     state   <= S_IDLE;
                     cnt_rst <= 1'b1;
                     busy    <= 1'b0;
                  end else if (cnt_q == limit_q) begin
                     done    <= 1'b1;
                     cnt_rst <= 1'b1;
`ifdef RIPPLE_SEQ_AUTO_RELOAD_EN
                     state   <= S_RELOAD;
`else
                     state   <= S_IDLE;
                     busy    <= 1'b0;
`endif
                  end else begin
                     state   <= S_PULSE;
                     cnt_clk <= 1'b1;
                  end
               end
`ifdef RIPPLE_SEQ_AUTO_RELOAD_EN
               S_RELOAD: begin
                  // Counter held in reset for this one cycle; rerun from zero.
                  shadow  <= '0;
                  cnt_rst <= 1'b0;
                  state   <= S_ARM;
               end
`endif
               default: begin
                  state   <= S_IDLE;
                  cnt_rst <= 1'b1;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
